// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - three-stage pipelined IEEE-754 single-precision multiplier
//
// Purpose:
//   Multiplies two binary32 operands with round-to-nearest-even. Special
//   operands (NaN, infinity, zero) are resolved in S1 and ride the pipe
//   alongside the arithmetic path. Denormal inputs are accepted and denormal
//   results are produced. Results leave in order, 3 cycles after accept.
//   The whole pipe advances together and stalls as a unit on backpressure.
//
// Ports:
//   clk        clock
//   rstn       synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   pipe accepts operands this cycle (~out_valid | out_ready)
//   x1, x2     multiplicand, multiplier (binary32)
//   in_tag     opaque tag carried with the operation
//   out_valid  result valid
//   out_ready  consumer accepts result
//   y          product (binary32)
//   ovf        finite*finite product overflowed to infinity
//   out_tag    tag of the current result
//   unf        underflow after rounding (only when FMUL_UNF_EN is defined)
//
// Build option:
//   FMUL_UNF_EN  adds the unf output port.

module fmul_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
`ifdef FMUL_UNF_EN
  ,
  output logic             unf
`endif
);

  // The pipe moves as one block: every stage advances whenever the output
  // register is empty or being drained this cycle.
  logic adv;
  assign in_ready = ~out_valid | out_ready;
  assign adv      = in_ready;

  // ---------------------------------------------------------------------
  // S1: unpack, classify specials, multiply significands
  // ---------------------------------------------------------------------
  logic        s_a, s_b, s_y;
  logic [7:0]  e_a, e_b;
  logic [22:0] f_a, f_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [23:0] m_a, m_b;
  logic [7:0]  ea_adj, eb_adj;
  logic [47:0] prod;
  logic [9:0]  et;
  logic        spec;
  logic [31:0] spec_y;

  assign s_a = x1[31];
  assign s_b = x2[31];
  assign s_y = s_a ^ s_b;
  assign e_a = x1[30:23];
  assign e_b = x2[30:23];
  assign f_a = x1[22:0];
  assign f_b = x2[22:0];

  assign a_nan  = (e_a == 8'hFF) && (f_a != 23'd0);
  assign b_nan  = (e_b == 8'hFF) && (f_b != 23'd0);
  assign a_inf  = (e_a == 8'hFF) && (f_a == 23'd0);
  assign b_inf  = (e_b == 8'hFF) && (f_b == 23'd0);
  assign a_zero = (e_a == 8'h00) && (f_a == 23'd0);
  assign b_zero = (e_b == 8'h00) && (f_b == 23'd0);

  // Denormals have no hidden one and behave as if their exponent were 1.
  assign m_a    = {(e_a != 8'h00), f_a};
  assign m_b    = {(e_b != 8'h00), f_b};
  assign ea_adj = (e_a == 8'h00) ? 8'd1 : e_a;
  assign eb_adj = (e_b == 8'h00) ? 8'd1 : e_b;

  assign prod = {24'd0, m_a} * {24'd0, m_b};
  // 10-bit two's complement: spans -125 .. +381 without wrapping.
  assign et   = {2'b00, ea_adj} + {2'b00, eb_adj} - 10'd127;

  // Priority order matters: a NaN on x1 wins over one on x2, and an
  // invalid 0*inf wins over the plain infinity and zero cases.
  always_comb begin
    spec   = 1'b1;
    spec_y = 32'd0;
    if (a_nan)
      spec_y = {s_a, 8'hFF, 1'b1, f_a[21:0]};
    else if (b_nan)
      spec_y = {s_b, 8'hFF, 1'b1, f_b[21:0]};
    else if ((a_zero && b_inf) || (a_inf && b_zero))
      spec_y = 32'hFFC0_0000;
    else if (a_inf || b_inf)
      spec_y = {s_y, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      spec_y = {s_y, 31'd0};
    else
      spec = 1'b0;
  end

  logic             v1;
  logic [TAG_W-1:0] t1;
  logic             sg1;
  logic [47:0]      p1;
  logic [9:0]       et1;
  logic             sp1;
  logic [31:0]      spy1;

  // ---------------------------------------------------------------------
  // S2: normalize, and denormalize when the exponent falls to zero or below
  // ---------------------------------------------------------------------
  logic [5:0]  k;
  logic [47:0] pn;
  logic [9:0]  e_norm;
  logic        den;
  logic [9:0]  sh_full;
  logic [5:0]  sh;
  logic [46:0] pd;
  logic        lost;
  logic [9:0]  e2_n;
  logic [22:0] man_n;
  logic        g_n, st_n;

  // Leading-one index; the highest set bit wins because it is written last.
  always_comb begin
    k = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (p1[i]) k = 6'(i);
    end
  end

  always_comb begin
    pn      = p1 << (6'd47 - k);
    // Bit 46 of the raw product carries weight 2^0 for normal operands.
    e_norm  = et1 + {4'd0, k} - 10'd46;
    den     = e_norm[9] || (e_norm == 10'd0);
    sh_full = 10'd1 - e_norm;
    sh      = (sh_full > 10'd48) ? 6'd48 : sh_full[5:0];
    if (den) begin
      pd   = 47'(pn >> sh);
      lost = |(pn & ~({48{1'b1}} << sh));
    end else begin
      pd   = pn[46:0];
      lost = 1'b0;
    end
    // A zero product has no leading one; force a clean signed zero.
    e2_n  = (den || (p1 == 48'd0)) ? 10'd0 : e_norm;
    man_n = pd[46:24];
    g_n   = pd[23];
    st_n  = (|pd[22:0]) | lost;
  end

  logic             v2;
  logic [TAG_W-1:0] t2;
  logic             sg2;
  logic [9:0]       e2;
  logic [22:0]      man2;
  logic             g2, st2;
  logic             sp2;
  logic [31:0]      spy2;

  // ---------------------------------------------------------------------
  // S3: round to nearest even, detect overflow, pack
  // ---------------------------------------------------------------------
  logic        rnd;
  logic [23:0] m_r;
  logic [9:0]  e_r;
  logic        of;
  logic [31:0] y_n;
  logic        ovf_n;
  logic        unf_n;

  // A mantissa carry bumps the exponent; this also turns a denormal that
  // rounds up to 1.0 into exponent 1 with a zero fraction.
  always_comb begin
    rnd   = g2 & (st2 | man2[0]);
    m_r   = {1'b0, man2} + {23'd0, rnd};
    e_r   = e2 + {9'd0, m_r[23]};
    of    = (e_r >= 10'd255);
    ovf_n = ~sp2 & of;
    unf_n = ~sp2 & ~of & (e_r[7:0] == 8'd0);
    if (sp2)
      y_n = spy2;
    else if (of)
      y_n = {sg2, 8'hFF, 23'd0};
    else
      y_n = {sg2, e_r[7:0], m_r[22:0]};
  end

`ifndef FMUL_UNF_EN
  logic unf_unused;
  assign unf_unused = unf_n;
`endif

  // ---------------------------------------------------------------------
  // Pipeline registers. Only valid bits and the visible outputs are reset;
  // stale data behind a cleared valid bit is never observed.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      y         <= 32'd0;
      ovf       <= 1'b0;
      out_tag   <= '0;
`ifdef FMUL_UNF_EN
      unf       <= 1'b0;
`endif
    end else if (adv) begin
      v1        <= in_valid;
      t1        <= in_tag;
      sg1       <= s_y;
      p1        <= prod;
      et1       <= et;
      sp1       <= spec;
      spy1      <= spec_y;

      v2        <= v1;
      t2        <= t1;
      sg2       <= sg1;
      e2        <= e2_n;
      man2      <= man_n;
      g2        <= g_n;
      st2       <= st_n;
      sp2       <= sp1;
      spy2      <= spy1;

      out_valid <= v2;
      out_tag   <= t2;
      y         <= y_n;
      ovf       <= ovf_n;
`ifdef FMUL_UNF_EN
      unf       <= unf_n;
`endif
    end
  end

endmodule
